watchdog_ctrl: RTL
==================

// Module: watchdog_ctrl
// PURPOSE
//  8-bit I/O-bus front end and access controller for the watchdog timer. Maps byte
//  accesses onto the watchdog's counter/reload/config strobes and commits 16-bit
//  values atomically. Guards reload/config with a two-key unlock FSM and provides a
//  keyed kick. Reports illegal accesses to the watchdog trap input.
// PARAMETERS
//  KEY1        8'h55  first unlock key
//  KEY2        8'hAA  second unlock key
//  KICK_KEY    8'hA5  value that must be written to KICK
//  UNLOCK_TO   16     cycles allowed in KEY1_SEEN/UNLOCKED before relock
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  io_addr        in   3   register select: 0 CNT_L, 1 CNT_H, 2 RLD_L, 3 RLD_H, 4 CFG, 5 KEY, 6 KICK, 7 STAT/WIN
//  io_wdata       in   8   write data
//  io_wr, io_rd   in   1   single-cycle access strobes
//  io_rdata       out  8   read data, valid the cycle after io_rd
//  counter_out    in   16  from watchdog
//  reload_out     in   16  from watchdog
//  config_out     in   8   from watchdog
//  counter_in     out  16  to watchdog
//  reload_in      out  16  to watchdog
//  config_in      out  8   to watchdog
//  counter_write  out  2   byte-lane strobes to watchdog
//  reload_write   out  2   byte-lane strobes to watchdog
//  config_write   out  1   strobe to watchdog
//  trap_req       out  1   one-cycle pulse on any access violation
// BEHAVIOUR
//  - Reset: all outputs 0, FSM LOCKED, shadow/staging 0, sticky status 0.
//  - Every strobe and its data are registered: asserted exactly 1 cycle after io_wr, for 1 cycle.
//  - FSM LOCKED -KEY=KEY1-> KEY1_SEEN -KEY=KEY2-> UNLOCKED. In KEY1_SEEN, any other KEY
//    write -> LOCKED + trap_req + STAT.key_fault. KEY writes in UNLOCKED are ignored.
//  - Timeout counter loads UNLOCK_TO on entry to KEY1_SEEN/UNLOCKED; at 0 -> LOCKED, no trap.
//  - UNLOCKED: RLD_L write updates an 8-bit staging reg only. RLD_H write drives reload_write=2'b11,
//    reload_in={wdata,staging}, then -> LOCKED. CFG write drives config_write, then -> LOCKED.
//  - RLD_L/RLD_H/CFG write while not UNLOCKED: ignored, trap_req, STAT.lock_fault; FSM unchanged.
//  - KICK write with KICK_KEY: counter_write=2'b11, counter_in=reload_out. Any other value:
//    ignored, trap_req, STAT.kick_fault. KICK works in every FSM state.
//  - Writes to CNT_L/CNT_H: ignored, no trap (counter is writable only by kick).
//  - Read CNT_L returns counter_out[7:0] and latches counter_out[15:8] into shadow.
//    CNT_H returns shadow -> coherent 16-bit read. RLD_*/CFG return live values.
//    KEY/KICK read 0. STAT = {3'b0, win_fault, kick_fault, lock_fault, key_fault, unlocked}.
//  - Read and write in the same cycle: the read returns the pre-write value.
//  - Sticky fault bits clear on STAT read. A fault in the same cycle as the read stays set.
//  - reset mid-sequence: FSM -> LOCKED and staging is lost. Pending strobes are dropped.
// CONFIGURATION
//  WATCHDOG_CTRL_WINDOW_EN defined: an address-7 write sets win_hi[7:0] (reset 0; needs
//    UNLOCKED, relocks after the write). A valid kick while counter_out < {win_hi,8'h00}
//    (too early) is rejected: trap_req and STAT.win_fault. STAT.win_fault is implemented.
//  Undefined: an address-7 write is ignored with no trap. All valid kicks are accepted.
//    STAT bit 4 reads 0.
// STRUCTURE
//  Package watchdog_ctrl_pkg: io address enum, FSM state enum, STAT bit indices, default keys.
//  Sub-module watchdog_unlock_fsm: key sequencing, timeout counter, unlocked/key_fault outputs.
//  Top: address decode, staging/shadow regs, strobe registers, fault/trap logic.
// TESTING
//  1. KEY 55, KEY AA, RLD_L 34, RLD_H 12 -> one-cycle reload_write=11, reload_in=1234; STAT.unlocked=0.
//  2. KEY 55, KEY 00 -> trap_req pulse and STAT=0x02. A following CFG write yields no config_write + trap.
//  3. KEY 55, KEY AA, idle 16 cycles, CFG 01 -> no config_write, trap_req, lock_fault.
//  4. counter_out=ABCD: read CNT_L, counter moves to ABCE, read CNT_H -> CD then AB.
//  5. KICK A5 with reload_out=F000 -> counter_write=11, counter_in=F000. KICK 5A -> trap, kick_fault.
//  6. (WINDOW_EN) win_hi=80, counter_out=7FFF, KICK A5 -> no counter_write, trap, win_fault.
//     Same kick at 8000 is accepted.

Source files
------------

// File: rtl/watchdog_ctrl_pkg.sv
// watchdog_ctrl_pkg: shared io address map, unlock FSM states, STAT bit indices and default keys.
package watchdog_ctrl_pkg;
    typedef enum logic [2:0] {
        A_CNT_L, A_CNT_H, A_RLD_L, A_RLD_H, A_CFG, A_KEY, A_KICK, A_STAT
    } io_addr_e;
    typedef enum logic [1:0] {LOCKED, KEY1_SEEN, UNLOCKED} state_e;
    localparam int STAT_UNLOCKED   = 0;
    localparam int STAT_KEY_FAULT  = 1;
    localparam int STAT_LOCK_FAULT = 2;
    localparam int STAT_KICK_FAULT = 3;
    localparam int STAT_WIN_FAULT  = 4;
    localparam logic [7:0] DEF_KEY1     = 8'h55;
    localparam logic [7:0] DEF_KEY2     = 8'hAA;
    localparam logic [7:0] DEF_KICK_KEY = 8'hA5;
    localparam int         DEF_UNLOCK_TO = 16;
endpackage

// File: rtl/watchdog_unlock_fsm.sv
// watchdog_unlock_fsm: two-key unlock sequencer with relock timeout; key_fault is a
// combinational pulse for a wrong second key.
module watchdog_unlock_fsm import watchdog_ctrl_pkg::*; #(
    parameter logic [7:0] KEY1      = DEF_KEY1,
    parameter logic [7:0] KEY2      = DEF_KEY2,
    parameter int         UNLOCK_TO = DEF_UNLOCK_TO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_wr,
    input  logic [7:0] key_data,
    input  logic       commit,
    output logic       unlocked,
    output logic       key_fault
);
    localparam int TW = $clog2(UNLOCK_TO + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(UNLOCK_TO - 1);
    state_e state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOCKED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end
    // Timer counts the cycles remaining in a keyed state; zero means this is the last one.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer == '0 ? timer : timer - 1'b1;
        key_fault = 1'b0;
        case (state)
            LOCKED: begin
                if (key_wr && key_data == KEY1) begin
                    state_nxt = KEY1_SEEN;
                    timer_nxt = TO_LOAD;
                end
            end
            KEY1_SEEN: begin
                if (key_wr && key_data == KEY2) begin
                    state_nxt = UNLOCKED;
                    timer_nxt = TO_LOAD;
                end else if (key_wr) begin
                    state_nxt = LOCKED;
                    key_fault = 1'b1;
                end else if (timer == '0) begin
                    state_nxt = LOCKED;
                end
            end
            UNLOCKED: state_nxt = (commit || timer == '0) ? LOCKED : UNLOCKED;
            default: state_nxt = LOCKED;
        endcase
    end
    assign unlocked = state == UNLOCKED;
endmodule

// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: 8-bit io front end and access guard for the watchdog timer.
// Define WATCHDOG_CTRL_WINDOW_EN to add the early-kick window (win_hi at address 7).
module watchdog_ctrl import watchdog_ctrl_pkg::*; #(
    parameter logic [7:0] KEY1      = DEF_KEY1,
    parameter logic [7:0] KEY2      = DEF_KEY2,
    parameter logic [7:0] KICK_KEY  = DEF_KICK_KEY,
    parameter int         UNLOCK_TO = DEF_UNLOCK_TO
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_wr,
    input  logic        io_rd,
    output logic [7:0]  io_rdata,
    input  logic [15:0] counter_out,
    input  logic [15:0] reload_out,
    input  logic [7:0]  config_out,
    output logic [15:0] counter_in,
    output logic [15:0] reload_in,
    output logic [7:0]  config_in,
    output logic [1:0]  counter_write,
    output logic [1:0]  reload_write,
    output logic        config_write,
    output logic        trap_req
);
    io_addr_e addr;
    logic unlocked, key_fault, wr_rld_l, wr_rld_h, wr_cfg, wr_win, wr_kick;
    logic guarded, commit, kick_ok, win_early, rld_go, cfg_go;
    logic [7:0] staging, shadow, sticky, faults, stat, rd_val;
    assign addr     = io_addr_e'(io_addr);
    assign wr_rld_l = io_wr && addr == A_RLD_L;
    assign wr_rld_h = io_wr && addr == A_RLD_H;
    assign wr_cfg   = io_wr && addr == A_CFG;
    assign wr_kick  = io_wr && addr == A_KICK;
`ifdef WATCHDOG_CTRL_WINDOW_EN
    logic [7:0] win_hi;
    assign wr_win    = io_wr && addr == A_STAT;
    assign win_early = counter_out < {win_hi, 8'h00};
    always_ff @(posedge clk) begin
        if (reset) win_hi <= '0;
        else if (wr_win && unlocked) win_hi <= io_wdata;
    end
`else
    assign wr_win    = 1'b0;
    assign win_early = 1'b0;
`endif
    assign guarded = wr_rld_l || wr_rld_h || wr_cfg || wr_win;
    assign commit  = unlocked && (wr_rld_h || wr_cfg || wr_win);
    assign rld_go  = unlocked && wr_rld_h;
    assign cfg_go  = unlocked && wr_cfg;
    assign kick_ok = wr_kick && io_wdata == KICK_KEY && !win_early;
    assign stat    = sticky | {7'b0, unlocked};
    watchdog_unlock_fsm #(.KEY1(KEY1), .KEY2(KEY2), .UNLOCK_TO(UNLOCK_TO)) u_fsm (
        .clk(clk), .reset(reset), .key_wr(io_wr && addr == A_KEY), .key_data(io_wdata),
        .commit(commit), .unlocked(unlocked), .key_fault(key_fault)
    );
    always_comb begin
        faults = '0;
        faults[STAT_KEY_FAULT]  = key_fault;
        faults[STAT_LOCK_FAULT] = guarded && !unlocked;
        faults[STAT_KICK_FAULT] = wr_kick && io_wdata != KICK_KEY;
        faults[STAT_WIN_FAULT]  = wr_kick && io_wdata == KICK_KEY && win_early;
    end
    always_comb begin
        rd_val = '0;
        case (addr)
            A_CNT_L: rd_val = counter_out[7:0];
            A_CNT_H: rd_val = shadow;
            A_RLD_L: rd_val = reload_out[7:0];
            A_RLD_H: rd_val = reload_out[15:8];
            A_CFG:   rd_val = config_out;
            A_STAT:  rd_val = stat;
            default: rd_val = '0;
        endcase
    end
    // A fault raised in the same cycle as a STAT read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_rdata      <= '0;
            shadow        <= '0;
            staging       <= '0;
            sticky        <= '0;
            trap_req      <= 1'b0;
            counter_write <= '0;
            counter_in    <= '0;
            reload_write  <= '0;
            reload_in     <= '0;
            config_write  <= 1'b0;
            config_in     <= '0;
        end else begin
            io_rdata      <= io_rd ? rd_val : io_rdata;
            shadow        <= (io_rd && addr == A_CNT_L) ? counter_out[15:8] : shadow;
            staging       <= (wr_rld_l && unlocked) ? io_wdata : staging;
            sticky        <= ((io_rd && addr == A_STAT) ? 8'h00 : sticky) | faults;
            trap_req      <= |faults;
            counter_write <= {2{kick_ok}};
            counter_in    <= kick_ok ? reload_out : '0;
            reload_write  <= {2{rld_go}};
            reload_in     <= rld_go ? {io_wdata, staging} : '0;
            config_write  <= cfg_go;
            config_in     <= cfg_go ? io_wdata : '0;
        end
    end
endmodule
